// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-side DataMemory arbiter: FSM encoding and client index.
package cache_mem_arbiter_pkg;

  localparam int NUM_CLIENTS = 2;
  localparam int CNT_W       = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } arb_state_t;

  typedef logic client_t;

  localparam client_t CLIENT_I = 1'b0;
  localparam client_t CLIENT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin grant; on a tie the client that did not win last time goes.
module rr_arbiter2
  import cache_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  client_t    last_grant,
  output logic       gnt_vld,
  output client_t    gnt
);

  always_comb begin
    gnt = CLIENT_I;
    if (req == 2'b11) gnt = client_t'(~last_grant);
    else if (req[1])  gnt = CLIENT_D;
  end

  assign gnt_vld = |req;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-granular DataMemory between the I-cache (client 0) and D-cache (client 1).
// One transaction in flight; client requests are latched and then replayed to memory.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_is_input_valid,
  input  logic [ADDR_W-1:0]      c0_addr,
  input  logic                   c0_mem_read,
  input  logic                   c0_mem_write,
  input  logic [LINE_SIZE*8-1:0] c0_din,
  output logic                   c0_is_output_valid,
  output logic [LINE_SIZE*8-1:0] c0_dout,
  output logic                   c0_mem_ready,
  input  logic                   c1_is_input_valid,
  input  logic [ADDR_W-1:0]      c1_addr,
  input  logic                   c1_mem_read,
  input  logic                   c1_mem_write,
  input  logic [LINE_SIZE*8-1:0] c1_din,
  output logic                   c1_is_output_valid,
  output logic [LINE_SIZE*8-1:0] c1_dout,
  output logic                   c1_mem_ready,
  output logic                   m_is_input_valid,
  output logic [ADDR_W-1:0]      m_addr,
  output logic                   m_mem_read,
  output logic                   m_mem_write,
  output logic [LINE_SIZE*8-1:0] m_din,
  input  logic                   m_is_output_valid,
  input  logic [LINE_SIZE*8-1:0] m_dout,
  input  logic                   m_mem_ready,
  output logic [CNT_W-1:0]       grant_count0,
  output logic [CNT_W-1:0]       grant_count1,
  output logic [CNT_W-1:0]       contention_count
);

  localparam int DW = LINE_SIZE * 8;

  arb_state_t state_q, state_d;
  client_t    owner_q, last_grant_q, gnt;
  logic       gnt_vld, accept, in_idle, rsp_vld, lat_wr_q;

  logic [ADDR_W-1:0] lat_addr_q;
  logic [DW-1:0]     lat_din_q;

  logic [NUM_CLIENTS-1:0][CNT_W-1:0] grant_cnt_q;
  logic [CNT_W-1:0]                  cont_cnt_q;

  // Arbitration keys off mem_read|mem_write: clients gate valid with ready, so
  // using valid here would close a combinational loop.
  logic [NUM_CLIENTS-1:0]             req, c_vld, c_wr, c_rdy;
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] c_addr;
  logic [NUM_CLIENTS-1:0][DW-1:0]     c_din;

  assign req    = {c1_mem_read | c1_mem_write, c0_mem_read | c0_mem_write};
  assign c_vld  = {c1_is_input_valid, c0_is_input_valid};
  assign c_wr   = {c1_mem_write, c0_mem_write};
  assign c_addr = {c1_addr, c0_addr};
  assign c_din  = {c1_din, c0_din};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  assign in_idle = (state_q == ST_IDLE);
  assign c_rdy   = (reset && in_idle && gnt_vld) ? (2'b01 << gnt) : 2'b00;
  assign accept  = |(c_rdy & c_vld);

  assign c0_mem_ready = c_rdy[0];
  assign c1_mem_ready = c_rdy[1];

  always_comb begin
    state_d            = state_q;
    m_is_input_valid   = 1'b0;
    m_mem_read         = 1'b0;
    m_mem_write        = 1'b0;
    rsp_vld            = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        m_is_input_valid = reset & m_mem_ready;
        m_mem_read       = ~lat_wr_q;
        m_mem_write      = lat_wr_q;
        // Writes are posted: the client already saw completion at acceptance.
        if (m_mem_ready) state_d = lat_wr_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        m_mem_read = 1'b1;
        rsp_vld    = reset & m_is_output_valid;
        if (m_is_output_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_addr = lat_addr_q;
  assign m_din  = lat_din_q;

  assign c0_is_output_valid = rsp_vld && (owner_q == CLIENT_I);
  assign c1_is_output_valid = rsp_vld && (owner_q == CLIENT_D);
  assign c0_dout            = c0_is_output_valid ? m_dout : '0;
  assign c1_dout            = c1_is_output_valid ? m_dout : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= CLIENT_I;
      last_grant_q <= CLIENT_D;
      lat_addr_q   <= '0;
      lat_din_q    <= '0;
      lat_wr_q     <= 1'b0;
      grant_cnt_q  <= '0;
      cont_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q          <= gnt;
        last_grant_q     <= gnt;
        lat_addr_q       <= c_addr[gnt];
        lat_din_q        <= c_din[gnt];
        lat_wr_q         <= c_wr[gnt];
        grant_cnt_q[gnt] <= grant_cnt_q[gnt] + 1'b1;
      end
      if (in_idle && (&req)) cont_cnt_q <= cont_cnt_q + 1'b1;
    end
  end

  assign grant_count0     = grant_cnt_q[0];
  assign grant_count1     = grant_cnt_q[1];
  assign contention_count = cont_cnt_q;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one line-granular DataMemory between two cache clients.
- Client 0 is the I-cache and client 1 is the D-cache; both use the Cache-to-DataMemory handshake.
- Sits between both caches' memory-side ports and the single DataMemory instance.
- Round-robin arbitration; one transaction in flight at a time. Client requests are latched, then replayed to memory.
- Keeps per-client grant counters and a contention counter for performance reporting.

Parameters:
- LINE_SIZE, 16: bytes per line; data width is LINE_SIZE*8.
- ADDR_W, 32: width of the line address (already shifted by CLOG2(LINE_SIZE)).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk.
- cN_is_input_valid  in  1  client N request strobe; N = 0, 1 for every cN_ port.
- cN_addr  in  ADDR_W  client N line address.
- cN_mem_read  in  1  client N wants a line read.
- cN_mem_write  in  1  client N wants a line write.
- cN_din  in  LINE_SIZE*8  client N write data.
- cN_is_output_valid  out  1  read data valid for client N (1-cycle pulse).
- cN_dout  out  LINE_SIZE*8  read data for client N; 0 when not valid.
- cN_mem_ready  out  1  arbiter accepts client N request this cycle.
- m_is_input_valid  out  1  request strobe to DataMemory.
- m_addr  out  ADDR_W  latched line address.
- m_mem_read  out  1  latched read.
- m_mem_write  out  1  latched write.
- m_din  out  LINE_SIZE*8  latched write data.
- m_is_output_valid  in  1  DataMemory read data valid.
- m_dout  in  LINE_SIZE*8  DataMemory read data.
- m_mem_ready  in  1  DataMemory can accept a request.
- grant_count0  out  32  requests accepted from client 0.
- grant_count1  out  32  requests accepted from client 1.
- contention_count  out  32  IDLE cycles in which both clients request.

Behaviour:
- Request indication: reqN = cN_mem_read | cN_mem_write.
  - Arbitration uses reqN, never cN_is_input_valid, because clients gate valid with ready.
  - This avoids a valid/ready combinational loop.
- States: IDLE, ISSUE, WAIT.
- IDLE, grant selection (combinational):
  - Exactly one req: that client is granted.
  - Both req: the client other than last_grant is granted.
  - Only the granted client sees cN_mem_ready=1; all other cN_mem_ready are 0.
- IDLE, acceptance:
  - A request is accepted on the cycle where the granted client has cN_is_input_valid & cN_mem_ready.
  - On acceptance, latch addr, din and rw (write if cN_mem_write, else read), set owner and last_grant to N, increment grant_countN, then go to ISSUE.
  - If a client asserts both mem_read and mem_write, it is treated as a write.
  - cN_is_input_valid from a non-granted client is ignored.
- ISSUE:
  - m_is_input_valid = m_mem_ready; m_* fields are driven from the latches.
  - On m_mem_ready: a write goes to IDLE (write is posted); a read goes to WAIT.
- WAIT:
  - On m_is_output_valid, drive cOwner_is_output_valid=1 and cOwner_dout=m_dout in the same cycle, then go to IDLE.
  - The non-owner client sees output_valid=0 and dout=0.
- m_mem_read/m_mem_write are asserted only in ISSUE and WAIT (read) or ISSUE (write); they are 0 in IDLE.
- Latency:
  - Earliest read: accept at cycle T, m_is_input_valid at T+1, client data at (memory valid cycle).
  - Next acceptance is no earlier than the cycle after returning to IDLE.
- A client sees its write as complete at acceptance; a following read from the same client re-arbitrates fairly.
- contention_count increments once per IDLE cycle with req0 & req1.
- All counters wrap modulo 2^32.
- Reset (reset==0 at posedge, in any state including mid-transaction):
  - State returns to IDLE, last_grant=1 (so client 0 wins first tie), all latches and counters are 0.
  - All registered outputs are 0.
  - cN_mem_ready and m_is_input_valid are forced to 0 while reset==0.
  - An in-flight memory response arriving after reset is dropped.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10) and a client-index typedef.
- One natural sub-module: rr_arbiter2, a combinational 2-way round-robin grant from req[1:0] and last_grant.
  - Reused later for the writeback-buffer path.

Test Plan:
- Read, client 0 only: c0 read of addr 0x10 → c0_mem_ready=1 in IDLE, m_addr=0x10 and m_mem_read=1 one cycle later, c0_is_output_valid with the memory line, grant_count0=1, c1 outputs remain 0.
- Simultaneous reads after reset: both request in the same cycle → client 0 is served first, then client 1; contention_count≥1; each dout matches its own address.
- Dirty eviction: c1 write of 0x20 then read of 0x30 while c0 continuously reads 0x40 → the order is c1 write, c0 read, c1 read; memory line 0x20 holds the c1 data.
- Back-pressure: hold m_mem_ready=0 for 5 cycles in ISSUE → m_is_input_valid stays 0, state holds, and there are no client grants.
- Mid-transaction reset: drive reset=0 while in WAIT → next cycle is IDLE with all counters 0; a late m_is_output_valid produces no client output_valid.
- Counter wrap: force grant_count0 to 32'hFFFFFFFF via a backdoor deposit, then complete one c0 request → grant_count0=0.
